// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the architectural PC and sequences instruction fetch.
//
// Fetches from a variable-latency instruction memory over a req/ack handshake.
// Each fetched instruction goes to decode over a valid/stall handshake.
// Resolved branches from execute redirect the PC. A fetch that waits too long
// for an ack sets a sticky timeout and halts the sequencer until reset.
//
// Ports:
//   CLK, resetl                     clock; synchronous active-low reset
//   startPC                         PC loaded while in reset
//   imem_req/imem_addr              fetch request and address (held until ack)
//   imem_ack/imem_rdata             memory accept and returned instruction
//   inst_valid/inst/inst_pc         registered instruction handed to decode
//   stall                           decode cannot accept inst this cycle
//   br_valid/br_pc/SignExtImm64/
//   Branch/ALUZero/Uncondbranch     branch resolution from execute
//   CurrentPC                       PC register (next fetch address)
//   timeout                         sticky fetch-timeout error
module pc_fetch_sequencer #(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned INST_W   = 32
) (
    input  logic              CLK,
    input  logic              resetl,
    input  logic [63:0]       startPC,
    output logic              imem_req,
    output logic [63:0]       imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [63:0]       inst_pc,
    input  logic              stall,
    input  logic              br_valid,
    input  logic [63:0]       br_pc,
    input  logic [63:0]       SignExtImm64,
    input  logic              Branch,
    input  logic              ALUZero,
    input  logic              Uncondbranch,
    output logic [63:0]       CurrentPC,
    output logic              timeout
);

    // Counter only needs to reach MAX_WAIT-1.
    localparam int unsigned CntW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    typedef enum logic [1:0] {StRst, StFetch, StDeliver, StHalt} state_e;

    state_e              state_q, state_d;
    logic [63:0]         pc_q, pc_d;
    logic [63:0]         req_addr_q, req_addr_d;
    logic                inst_valid_q, inst_valid_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic [63:0]         inst_pc_q, inst_pc_d;
    logic                timeout_q, timeout_d;
    logic                squash_q, squash_d;
    logic [CntW-1:0]     wait_cnt_q, wait_cnt_d;

    logic                taken;
    logic [63:0]         target;
    logic                wait_expired;
    logic                unused_imm_hi;

    assign taken  = br_valid & (Uncondbranch | (Branch & ALUZero));
    // Word offset; top two immediate bits shift out and the sum wraps.
    assign target = br_pc + {SignExtImm64[61:0], 2'b00};
    assign unused_imm_hi = ^SignExtImm64[63:62];

    assign wait_expired = (MAX_WAIT != 0) && (wait_cnt_q == CntW'(MAX_WAIT - 1));

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        timeout_d    = timeout_q;
        squash_d     = squash_q;
        wait_cnt_d   = wait_cnt_q;

        unique case (state_q)
            StRst: begin
                state_d    = StFetch;
                req_addr_d = pc_q;
                wait_cnt_d = '0;
            end
            StFetch: begin
                if (imem_ack) begin
                    wait_cnt_d = '0;
                    if (squash_q || taken) begin
                        // Returned data belongs to a redirected-away path.
                        pc_d       = taken ? target : pc_q;
                        req_addr_d = taken ? target : pc_q;
                        squash_d   = 1'b0;
                    end else begin
                        inst_d       = imem_rdata;
                        inst_pc_d    = req_addr_q;
                        inst_valid_d = 1'b1;
                        pc_d         = req_addr_q + 64'd4;
                        state_d      = StDeliver;
                    end
                end else begin
                    // Outstanding request cannot be aborted; remember to drop it.
                    if (taken) begin
                        pc_d     = target;
                        squash_d = 1'b1;
                    end
                    if (wait_expired) begin
                        timeout_d = 1'b1;
                        state_d   = StHalt;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CntW'(1);
                    end
                end
            end
            StDeliver: begin
                // Redirect wins over stall.
                if (taken) begin
                    inst_valid_d = 1'b0;
                    pc_d         = target;
                    req_addr_d   = target;
                    wait_cnt_d   = '0;
                    state_d      = StFetch;
                end else if (!stall) begin
                    inst_valid_d = 1'b0;
                    req_addr_d   = pc_q;
                    wait_cnt_d   = '0;
                    state_d      = StFetch;
                end
            end
            StHalt: begin
                inst_valid_d = 1'b0;
                timeout_d    = 1'b1;
            end
            default: state_d = StRst;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!resetl) begin
            state_q      <= StRst;
            pc_q         <= startPC;
            req_addr_q   <= startPC;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            timeout_q    <= 1'b0;
            squash_q     <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            timeout_q    <= timeout_d;
            squash_q     <= squash_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign imem_req   = (state_q == StFetch);
    assign imem_addr  = req_addr_q;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign CurrentPC  = pc_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: scoreboard bench for pc_fetch_sequencer.
//
// The stimulus thread drives directed vectors and pushes the expected fetch
// address of every acked request and every expected delivered instruction.
// A negedge monitor pops and compares whenever the DUT accepts a fetch or
// presents a new instruction. Direct checks cover reset, stall hold,
// redirects and the timeout.
module tb_pc_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        resetl;
    logic [63:0] startPC;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        stall;
    logic        br_valid;
    logic [63:0] br_pc;
    logic [63:0] SignExtImm64;
    logic        Branch;
    logic        ALUZero;
    logic        Uncondbranch;
    logic [63:0] CurrentPC;
    logic        timeout;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] exp_req[$];
    logic [31:0] exp_inst[$];
    logic [63:0] exp_ipc[$];
    logic        prev_valid = 1'b0;

    always #5 CLK = ~CLK;

    pc_fetch_sequencer #(
        .MAX_WAIT (4),
        .INST_W   (32)
    ) dut (
        .CLK          (CLK),
        .resetl       (resetl),
        .startPC      (startPC),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .stall        (stall),
        .br_valid     (br_valid),
        .br_pc        (br_pc),
        .SignExtImm64 (SignExtImm64),
        .Branch       (Branch),
        .ALUZero      (ALUZero),
        .Uncondbranch (Uncondbranch),
        .CurrentPC    (CurrentPC),
        .timeout      (timeout)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_br(input logic [63:0] pc, input logic [63:0] imm, input logic b,
                          input logic z, input logic u);
        br_valid     = 1'b1;
        br_pc        = pc;
        SignExtImm64 = imm;
        Branch       = b;
        ALUZero      = z;
        Uncondbranch = u;
    endtask

    task automatic clr_br();
        br_valid     = 1'b0;
        br_pc        = '0;
        SignExtImm64 = '0;
        Branch       = 1'b0;
        ALUZero      = 1'b0;
        Uncondbranch = 1'b0;
    endtask

    // Ack the current request this cycle; optionally expect a delivery.
    task automatic ack_now(input logic [63:0] addr, input logic [31:0] data, input bit deliver);
        imem_ack   = 1'b1;
        imem_rdata = data;
        exp_req.push_back(addr);
        if (deliver) begin
            exp_inst.push_back(data);
            exp_ipc.push_back(addr);
        end
    endtask

    // Monitor: compare against the scoreboard whenever the DUT presents something.
    always @(negedge CLK) begin
        if (resetl) begin
            if (imem_req && imem_ack) begin
                if (exp_req.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_ack: got addr %h, want no request", imem_addr);
                end else begin
                    chk("mon_req_addr", imem_addr, exp_req.pop_front());
                end
            end
            if (inst_valid && !prev_valid) begin
                if (exp_inst.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_inst: got %h @ %h, want none", inst, inst_pc);
                end else begin
                    chk("mon_inst", {32'h0, inst}, {32'h0, exp_inst.pop_front()});
                    chk("mon_inst_pc", inst_pc, exp_ipc.pop_front());
                end
            end
        end
        prev_valid = inst_valid;
    end

    initial begin
        resetl     = 1'b0;
        startPC    = 64'h10;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        stall      = 1'b0;
        clr_br();

        step();
        step();
        chk("rst_req", imem_req, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_pc", CurrentPC, 64'h10);
        chk("rst_inst", {32'h0, inst}, 0);

        resetl = 1'b1;
        step();
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 64'h10);
        chk("first_pc", CurrentPC, 64'h10);

        ack_now(64'h10, 32'hAAAA_0001, 1'b1);
        step();
        imem_ack = 1'b0;
        chk("seq_valid", inst_valid, 1);
        chk("seq_inst_pc", inst_pc, 64'h10);
        chk("seq_pc", CurrentPC, 64'h14);

        // Stall holds the delivered instruction and issues no fetch.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", inst_valid, 1);
            chk("stall_inst", {32'h0, inst}, 64'hAAAA_0001);
            chk("stall_inst_pc", inst_pc, 64'h10);
            chk("stall_noreq", imem_req, 0);
        end
        stall = 1'b0;
        step();
        chk("post_stall_req", imem_req, 1);
        chk("post_stall_addr", imem_addr, 64'h14);

        ack_now(64'h14, 32'hAAAA_0002, 1'b1);
        step();
        imem_ack = 1'b0;

        // Conditional taken: 0x10 + (2<<2) = 0x18, redirect beats stall.
        stall = 1'b1;
        set_br(64'h10, 64'd2, 1'b1, 1'b1, 1'b0);
        step();
        clr_br();
        stall = 1'b0;
        chk("brA_req", imem_req, 1);
        chk("brA_addr", imem_addr, 64'h18);

        ack_now(64'h18, 32'hAAAA_0003, 1'b1);
        step();
        imem_ack = 1'b0;

        // Conditional not taken: no effect, stall still holds.
        stall = 1'b1;
        set_br(64'h10, 64'd2, 1'b1, 1'b0, 1'b0);
        step();
        chk("brB_noreq", imem_req, 0);
        chk("brB_pc", CurrentPC, 64'h1C);
        clr_br();
        stall = 1'b0;
        step();
        chk("brB_addr", imem_addr, 64'h1C);

        ack_now(64'h1C, 32'hAAAA_0004, 1'b1);
        step();
        imem_ack = 1'b0;

        // Unconditional: 0x10 + (4<<2) = 0x20.
        stall = 1'b1;
        set_br(64'h10, 64'd4, 1'b0, 1'b0, 1'b1);
        step();
        clr_br();
        stall = 1'b0;
        chk("brC_req", imem_req, 1);
        chk("brC_addr", imem_addr, 64'h20);

        ack_now(64'h20, 32'hAAAA_0005, 1'b1);
        step();
        imem_ack = 1'b0;
        chk("brC_fall_pc", CurrentPC, 64'h24);

        // Negative offset: 0x100 + (-4<<2) = 0xF0.
        stall = 1'b1;
        set_br(64'h100, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 1'b1);
        step();
        clr_br();
        stall = 1'b0;
        chk("brD_addr", imem_addr, 64'hF0);
        chk("brD_pc", CurrentPC, 64'hF0);

        // Redirect to 0x40 while the fetch at 0xF0 is outstanding.
        set_br(64'h30, 64'd4, 1'b0, 1'b0, 1'b1);
        step();
        clr_br();
        chk("pend_addr0", imem_addr, 64'hF0);
        chk("pend_pc", CurrentPC, 64'h40);
        chk("pend_valid", inst_valid, 0);
        step();
        chk("pend_addr1", imem_addr, 64'hF0);
        step();
        chk("pend_addr2", imem_addr, 64'hF0);
        ack_now(64'hF0, 32'hDEAD_BEEF, 1'b0);
        step();
        imem_ack = 1'b0;
        chk("squash_valid", inst_valid, 0);
        chk("squash_req", imem_req, 1);
        chk("squash_addr", imem_addr, 64'h40);

        ack_now(64'h40, 32'hAAAA_0006, 1'b1);
        step();
        imem_ack = 1'b0;
        step();
        chk("after_squash_addr", imem_addr, 64'h44);

        // Ack and taken branch in the same cycle: data dropped, refetch 0x80.
        ack_now(64'h44, 32'hBAD0_BAD0, 1'b0);
        set_br(64'h70, 64'd4, 1'b0, 1'b0, 1'b1);
        step();
        clr_br();
        imem_ack = 1'b0;
        chk("ackbr_valid", inst_valid, 0);
        chk("ackbr_addr", imem_addr, 64'h80);
        chk("ackbr_pc", CurrentPC, 64'h80);

        // Timeout with MAX_WAIT=4: HALT after the 4th unacked FETCH cycle.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("to_pending", timeout, 0);
            chk("to_pending_req", imem_req, 1);
        end
        step();
        chk("to_set", timeout, 1);
        chk("to_noreq", imem_req, 0);
        chk("to_valid", inst_valid, 0);
        step();
        step();
        chk("to_sticky", timeout, 1);
        chk("to_sticky_noreq", imem_req, 0);

        resetl  = 1'b0;
        startPC = 64'h200;
        step();
        chk("rst2_timeout", timeout, 0);
        chk("rst2_req", imem_req, 0);
        chk("rst2_pc", CurrentPC, 64'h200);
        resetl = 1'b1;
        step();
        chk("rst2_fetch_req", imem_req, 1);
        chk("rst2_fetch_addr", imem_addr, 64'h200);

        step();
        chk("req_queue_empty", 64'(exp_req.size()), 0);
        chk("inst_queue_empty", 64'(exp_inst.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
